// File: rtl/rr_queue_drain.sv
// rr_queue_drain: round-robin packet drain from NUM_PORT show-ahead queues
// into one registered valid/ready stream. A granted queue is drained up to
// its eop word (or cut at MAX_LEN words), then the arbiter moves on.

// Per-queue pop gate: a queue pops only when it holds the grant, the
// transfer stage is allowed to load, and it actually has a head word.
module rr_queue_lane (
  input  logic sel,
  input  logic xfer_en,
  input  logic empty,
  output logic rd
);
  assign rd = sel & xfer_en & ~empty;
endmodule

module rr_queue_drain #(
  parameter int DATA_BIT = 9,
  parameter int PORT_W   = 2,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 5,
  localparam int NUM_PORT = 2**PORT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORT-1:0]          fifo_empty,
  input  logic [NUM_PORT*DATA_BIT-1:0] fifo_r_data,
  output logic [NUM_PORT-1:0]          fifo_rd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_BIT-2:0]          out_data,
  output logic                         out_last,
  output logic [PORT_W-1:0]            out_port,
  output logic                         trunc_pulse
);

  typedef enum logic {IDLE, XFER} state_t;

  // registered output word
  typedef struct packed {
    logic                vld;
    logic                last;
    logic [PORT_W-1:0]   port;
    logic [DATA_BIT-2:0] data;
  } out_word_t;

  state_t                              state;
  logic [PORT_W-1:0]                   grant;
  logic [PORT_W-1:0]                   last_grant;
  logic [LEN_W-1:0]                    cnt;
  out_word_t                           ow;
  logic                                trunc_q;

  logic [NUM_PORT-1:0][DATA_BIT-1:0]   head;
  logic [DATA_BIT-1:0]                 head_w;
  logic                                load_ok;
  logic                                xfer_en;
  logic                                pop;
  logic                                eop;
  logic                                at_max;
  logic                                nxt_found;
  logic [PORT_W-1:0]                   nxt_grant;
  logic [PORT_W-1:0]                   idx;

  // packed view: head[i] is queue i's word
  assign head    = fifo_r_data;
  assign head_w  = head[grant];
  assign eop     = head_w[DATA_BIT-1];
  assign at_max  = (cnt == LEN_W'(MAX_LEN-1));
  assign load_ok = !ow.vld || out_ready;
  // rst gates pops combinationally so nothing is lost while reset is held
  assign xfer_en = (state == XFER) && load_ok && !rst;
  assign pop     = |fifo_rd;

  for (genvar i = 0; i < NUM_PORT; i++) begin : g_lane
    rr_queue_lane u_lane (
      .sel     (grant == PORT_W'(i)),
      .xfer_en (xfer_en),
      .empty   (fifo_empty[i]),
      .rd      (fifo_rd[i])
    );
  end

  // round-robin search from last_grant+1; descending loop so the nearest
  // non-empty port wins, last_grant itself (k=NUM_PORT) has lowest priority
  always_comb begin
    nxt_found = 1'b0;
    nxt_grant = last_grant;
    idx       = '0;
    for (int k = NUM_PORT; k >= 1; k--) begin
      idx = last_grant + PORT_W'(k);
      if (!fifo_empty[idx]) begin
        nxt_found = 1'b1;
        nxt_grant = idx;
      end
    end
  end

  // arbitration / packet FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= '1;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (nxt_found) begin
            grant <= nxt_grant;
            cnt   <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          if (pop) begin
            if (eop || at_max) begin
              // packet done or cut; remainder of a cut packet re-arbitrates
              last_grant <= grant;
              cnt        <= '0;
              state      <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // output register: reload on pop, drop valid once accepted, hold on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ow      <= '0;
      trunc_q <= 1'b0;
    end else begin
      trunc_q <= pop && !eop && at_max;
      if (load_ok) begin
        if (pop) begin
          ow.vld  <= 1'b1;
          ow.last <= eop || at_max;
          ow.port <= grant;
          ow.data <= head_w[DATA_BIT-2:0];
        end else begin
          ow.vld  <= 1'b0;
        end
      end
    end
  end

  assign out_valid   = ow.vld;
  assign out_last    = ow.last;
  assign out_port    = ow.port;
  assign out_data    = ow.data;
  assign trunc_pulse = trunc_q;

endmodule

// File: tb/tb_rr_queue_drain.sv
// Directed bench for rr_queue_drain: four show-ahead queue models, an
// output capture log and a pop-rule monitor. MAX_LEN is set to 4 so that
// truncation is reachable with short packets.
module tb_rr_queue_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  fifo_empty;
  logic [35:0] fifo_r_data;
  logic [3:0]  fifo_rd;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_port;
  logic        trunc_pulse;

  rr_queue_drain #(.DATA_BIT(9), .PORT_W(2), .MAX_LEN(4), .LEN_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_r_data (fifo_r_data),
    .fifo_rd     (fifo_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_port    (out_port),
    .trunc_pulse (trunc_pulse)
  );

  always #5 clk = ~clk;

  // queue models
  logic [8:0]  mem [4][32];
  logic [4:0]  wr_ptr [4] = '{default: '0};
  logic [4:0]  rd_ptr [4] = '{default: '0};

  always_comb begin
    fifo_empty  = '1;
    fifo_r_data = '0;
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]          = (rd_ptr[i] == wr_ptr[i]);
      fifo_r_data[i*9 +: 9]  = mem[i][rd_ptr[i]];
    end
  end

  // capture log, pops, pulse count and pop-rule violations
  logic [10:0] cap [64];
  int          cap_cyc [64];
  int          ncap   = 0;
  int          cyc    = 0;
  int          ntrunc = 0;
  int          viol   = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++)
      if (fifo_rd[i]) rd_ptr[i] <= rd_ptr[i] + 5'd1;
    if (!rst && out_valid && out_ready && ncap < 64) begin
      cap[ncap]     <= {out_port, out_last, out_data};
      cap_cyc[ncap] <= cyc;
      ncap          <= ncap + 1;
    end
    if (trunc_pulse) ntrunc <= ntrunc + 1;
    if ($countones(fifo_rd) > 1 || (fifo_rd & fifo_empty) != 4'd0 ||
        (rst && fifo_rd != 4'd0))
      viol <= viol + 1;
  end

  int nchk  = 0;
  int nfail = 0;
  int base;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_w(input string tag, input int i, input logic [1:0] p,
                       input logic l, input logic [7:0] d);
    chk(tag, {21'd0, cap[i]}, {21'd0, p, l, d});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input int p, input logic [8:0] w);
    mem[p][wr_ptr[p]] = w;
    wr_ptr[p] = wr_ptr[p] + 5'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
  endtask

  task automatic wait_cap(input int n, input string tag);
    int b;
    b = 0;
    while (ncap < n && b < 200) begin
      step();
      b++;
    end
    chk(tag, 32'(ncap >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_last",  out_last, 0);
    chk("rst_port",  out_port, 0);
    chk("rst_trunc", trunc_pulse, 0);
    chk("rst_rd",    fifo_rd, 0);

    // T1: port 0, 3 words, cycle-exact
    push(0, 9'h011); push(0, 9'h022); push(0, 9'h133);
    rst = 1'b0;
    base = ncap;
    step();
    chk("t1_rd_c1", fifo_rd, 4'b0001);
    chk("t1_v_c1",  out_valid, 0);
    step();
    chk("t1_v_c2",  out_valid, 1);
    chk("t1_d_c2",  out_data, 8'h11);
    chk("t1_l_c2",  out_last, 0);
    chk("t1_rd_c2", fifo_rd, 4'b0001);
    step();
    chk("t1_d_c3",  out_data, 8'h22);
    chk("t1_rd_c3", fifo_rd, 4'b0001);
    step();
    chk("t1_d_c4",  out_data, 8'h33);
    chk("t1_l_c4",  out_last, 1);
    chk("t1_p_c4",  out_port, 0);
    chk("t1_rd_c4", fifo_rd, 0);
    step();
    chk("t1_v_c5",  out_valid, 0);
    chk("t1_n",     ncap - base, 3);

    // T2: ports 1 and 2 alternate; port 1's second packet waits for port 2
    do_reset();
    push(1, 9'h041); push(1, 9'h142); push(1, 9'h061); push(1, 9'h162);
    push(2, 9'h051); push(2, 9'h152);
    rst = 1'b0;
    base = ncap;
    wait_cap(base + 6, "t2_done");
    chk_w("t2_w0", base + 0, 2'd1, 1'b0, 8'h41);
    chk_w("t2_w1", base + 1, 2'd1, 1'b1, 8'h42);
    chk_w("t2_w2", base + 2, 2'd2, 1'b0, 8'h51);
    chk_w("t2_w3", base + 3, 2'd2, 1'b1, 8'h52);
    chk_w("t2_w4", base + 4, 2'd1, 1'b0, 8'h61);
    chk_w("t2_w5", base + 5, 2'd1, 1'b1, 8'h62);
    chk("t2_gap_in",  cap_cyc[base+1] - cap_cyc[base+0], 1);
    chk("t2_gap_pk1", cap_cyc[base+2] - cap_cyc[base+1], 2);
    chk("t2_gap_pk2", cap_cyc[base+4] - cap_cyc[base+3], 2);

    // T3: back-pressure for 3 cycles after the second word
    do_reset();
    push(0, 9'h071); push(0, 9'h072); push(0, 9'h073); push(0, 9'h174);
    rst = 1'b0;
    base = ncap;
    step();
    step();
    step();
    chk("t3_d_pre", out_data, 8'h72);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t3_hold_d%0d", i), out_data, 8'h72);
      chk($sformatf("t3_hold_v%0d", i), out_valid, 1);
      chk($sformatf("t3_hold_rd%0d", i), fifo_rd, 0);
    end
    out_ready = 1'b1;
    wait_cap(base + 4, "t3_done");
    repeat (4) step();
    chk("t3_n", ncap - base, 4);
    chk_w("t3_w0", base + 0, 2'd0, 1'b0, 8'h71);
    chk_w("t3_w1", base + 1, 2'd0, 1'b0, 8'h72);
    chk_w("t3_w2", base + 2, 2'd0, 1'b0, 8'h73);
    chk_w("t3_w3", base + 3, 2'd0, 1'b1, 8'h74);

    // T4: port 3 runs dry mid-packet; port 0 must wait
    do_reset();
    push(3, 9'h081); push(3, 9'h082);
    rst = 1'b0;
    base = ncap;
    wait_cap(base + 2, "t4_first2");
    push(0, 9'h091); push(0, 9'h192);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t4_stall_rd%0d", i), fifo_rd, 0);
    end
    chk("t4_stall_n", ncap - base, 2);
    push(3, 9'h183);
    wait_cap(base + 5, "t4_done");
    chk_w("t4_w0", base + 0, 2'd3, 1'b0, 8'h81);
    chk_w("t4_w1", base + 1, 2'd3, 1'b0, 8'h82);
    chk_w("t4_w2", base + 2, 2'd3, 1'b1, 8'h83);
    chk_w("t4_w3", base + 3, 2'd0, 1'b0, 8'h91);
    chk_w("t4_w4", base + 4, 2'd0, 1'b1, 8'h92);

    // T5: 6-word packet on port 2 is cut after 4 words
    do_reset();
    push(2, 9'h0A1); push(2, 9'h0A2); push(2, 9'h0A3);
    push(2, 9'h0A4); push(2, 9'h0A5); push(2, 9'h1A6);
    rst = 1'b0;
    base = ncap;
    wait_cap(base + 6, "t5_done");
    chk_w("t5_w0", base + 0, 2'd2, 1'b0, 8'hA1);
    chk_w("t5_w2", base + 2, 2'd2, 1'b0, 8'hA3);
    chk_w("t5_w3", base + 3, 2'd2, 1'b1, 8'hA4);
    chk_w("t5_w4", base + 4, 2'd2, 1'b0, 8'hA5);
    chk_w("t5_w5", base + 5, 2'd2, 1'b1, 8'hA6);
    chk("t5_gap", cap_cyc[base+4] - cap_cyc[base+3], 2);
    chk("t5_trunc", ntrunc, 1);

    // T6: reset mid-packet after the second word has been popped
    do_reset();
    push(0, 9'h0B1); push(0, 9'h0B2); push(0, 9'h0B3);
    push(0, 9'h0B4); push(0, 9'h1B5);
    rst = 1'b0;
    step();
    step();
    step();
    chk("t6_d_pre", out_data, 8'hB2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_v",  out_valid, 0);
    chk("t6_rst_rd", fifo_rd, 0);
    chk("t6_rst_d",  out_data, 0);
    step();
    chk("t6_rst_rd2", fifo_rd, 0);
    rst = 1'b0;
    base = ncap;
    wait_cap(base + 3, "t6_done");
    chk_w("t6_w0", base + 0, 2'd0, 1'b0, 8'hB3);
    chk_w("t6_w1", base + 1, 2'd0, 1'b0, 8'hB4);
    chk_w("t6_w2", base + 2, 2'd0, 1'b1, 8'hB5);
    repeat (3) step();
    chk("t6_drained", {27'd0, rd_ptr[0]}, {27'd0, wr_ptr[0]});

    chk("rd_rules", viol, 0);
    chk("trunc_total", ntrunc, 1);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/rr_queue_drain.md
Name: rr_queue_drain

Overview:
- Downstream consumer of the per-port input queues in the shared-cache switch.
- Watches up to 2**PORT_W show-ahead FIFOs and picks one non-empty queue by round-robin.
- Drains the whole packet from that queue (up to end-of-packet) into a single registered valid/ready output stream, then re-arbitrates.
- Guards against runaway packets with a maximum-length truncation.

Parameters:
- DATA_BIT, 9, width of each FIFO word; bit DATA_BIT-1 is the end-of-packet (eop) flag, bits DATA_BIT-2:0 are payload.
- PORT_W, 2, port index width; NUM_PORT = 2**PORT_W queues.
- MAX_LEN, 16, maximum words per packet before forced truncation (≥2).
- LEN_W, 5, counter width; must hold MAX_LEN.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  NUM_PORT  per-queue empty flag; bit i = queue i.
- fifo_r_data  in  NUM_PORT*DATA_BIT  head word of queue i at [i*DATA_BIT +: DATA_BIT]; valid whenever fifo_empty[i]=0.
- fifo_rd  out  NUM_PORT  one-hot pop strobe, combinational; queue pops at the clock edge.
- out_valid  out  1  output word valid (registered).
- out_ready  in  1  downstream accept.
- out_data  out  DATA_BIT-1  payload (registered).
- out_last  out  1  last word of packet (registered).
- out_port  out  PORT_W  source queue of out_data (registered).
- trunc_pulse  out  1  one-cycle pulse when a packet was cut at MAX_LEN.

Behaviour:
- Reset values (asynchronous, rst=1):
  - out_valid, out_data, out_last, out_port, trunc_pulse = 0.
  - fifo_rd = 0; state = IDLE; word count = 0; last_grant = NUM_PORT-1, so port 0 has first priority.
- Output register:
  - The register may load when load_ok = !out_valid || out_ready.
  - out_valid drops to 0 after out_ready=1 if nothing new is loaded that cycle.
  - While out_valid=1 and out_ready=0, out_data, out_last and out_port hold stable.
- State IDLE:
  - Search ports last_grant+1, +2, ... modulo NUM_PORT; grant the first with fifo_empty=0.
  - Register grant, clear count, go to XFER.
  - No pop in IDLE; arbitration costs one cycle.
  - If all queues are empty, stay in IDLE.
- State XFER, pop condition:
  - When fifo_empty[grant]=0 and load_ok, assert fifo_rd[grant]=1 for that cycle.
  - On the same edge, load out_data = head payload, out_port = grant, out_valid = 1.
  - out_last = eop || (count == MAX_LEN-1); then count increments.
- State XFER, end of packet:
  - If the popped word had eop=1: last_grant <= grant, go to IDLE.
  - Else if count == MAX_LEN-1 (truncation): out_last=1, trunc_pulse=1 next cycle, last_grant <= grant, go to IDLE.
  - After a truncation, the remaining words of that packet are treated as a new packet when the port is next granted.
- State XFER, stalls:
  - If fifo_empty[grant]=1 mid-packet, stall in XFER holding the grant; other ports are not served.
  - If load_ok=0, no pop occurs.
- Pop rules:
  - fifo_rd is never asserted for a port other than grant.
  - fifo_rd is never asserted when that port's empty=1 or in IDLE.
  - At most one fifo_rd bit is high per cycle.
- Throughput: one word per cycle with out_ready held at 1; 1 idle cycle between packets.
- Latency: a non-empty queue with the block in IDLE and the output free gives first out_valid 2 cycles later.
- Wrap-around: the arbiter pointer wraps NUM_PORT-1 → 0. The count saturates logically via the truncation rule and never exceeds MAX_LEN-1.
- Reset mid-packet: everything returns to reset values immediately. No fifo_rd is issued while rst=1. A partially drained packet resumes as a new packet from its current head word.
- Simultaneous events: a pop and an out_ready handshake in the same cycle is the normal streaming case. The register reloads and out_valid stays 1.

Test Plan:
- Port 0 holds 3 words, payloads 0x11, 0x22, 0x33, eop on the last; out_ready=1 → fifo_rd[0] pulses 3 consecutive cycles; out_data 0x11, 0x22, 0x33; out_last=1 only on 0x33; out_port=0; first out_valid 2 cycles after release.
- Ports 1 and 2 each hold one 2-word packet; ports 0 and 3 are empty; after reset → port 1 packet fully, 1 idle cycle, then port 2 packet; next port 1 packet is served only after port 2.
- Port 0 streaming 4 words with out_ready=0 for 3 cycles after the second word → out_data holds the second word for 3 cycles; fifo_rd=0 during the stall; no word lost or duplicated.
- Port 3 gives 2 words, then fifo_empty[3]=1 for 5 cycles while port 0 is non-empty → grant stays 3, no pops; the remaining eop word drains when the queue refills; port 0 is served next.
- MAX_LEN=4, port 2 holds a 6-word packet → 4 words out, 4th has out_last=1, trunc_pulse=1 once; the remaining 2 words go out as a separate packet on a later grant.
- Assert rst for 1 cycle after the 2nd word of a 5-word packet → out_valid=0 immediately; fifo_rd=0; after release, port 0 is searched first; the 3rd word is the first output word.
